bus_regfile: RTL and testbench

Parametrised register file with a registered, priority-arbitrated shared bus for the simple-processor datapath. It replaces the combinational bus multiplexer with a clocked unit. The unit holds N general registers of W bits, selects one bus source per cycle (DIN, G, or one register), and loads the bus value into any subset of registers. It also holds the bus when nothing drives it and flags illegal multi-hot register selects.

---
 rtl/bus_regfile.sv | 75 +++++++
 tb/tb_bus_regfile.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_regfile.sv
// Clocked shared bus with priority source select (DIN > G > one-hot register)
// feeding an N x W register file; holds the bus when undriven and counts multi-hot selects.
module bus_regfile #(
  parameter int W = 16,
  parameter int N = 8
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic [W-1:0]         DIN,
  input  logic                 DINout,
  input  logic [W-1:0]         G,
  input  logic                 Gout,
  input  logic [N-1:0]         Rout,
  input  logic [N-1:0]         Rin,
  input  logic [$clog2(N)-1:0] RdSel,
  output logic [W-1:0]         Bus,
  output logic                 BusValid,
  output logic                 SelErr,
  output logic [7:0]           ErrCnt,
  output logic [W-1:0]         RdData
);

  localparam int SW = $clog2(N);

  logic [W-1:0] regs [N];
  logic [W-1:0] rsrc;
  logic [W-1:0] nxt;
  logic         rout_any;
  logic         rout_onehot;
  logic         driven;
  logic         multihot;

  always_comb begin
    rsrc = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (Rout[k]) rsrc = rsrc | regs[k];
    end
    rout_any    = |Rout;
    // x & (x-1) clears the lowest set bit, so zero means at most one bit was set
    rout_onehot = rout_any && ((Rout & (Rout - N'(1))) == '0);
    driven      = DINout | Gout | rout_onehot;
    multihot    = !DINout && !Gout && rout_any && !rout_onehot;
    if (DINout)    nxt = DIN;
    else if (Gout) nxt = G;
    else           nxt = rsrc;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      Bus      <= '0;
      BusValid <= 1'b0;
      SelErr   <= 1'b0;
      ErrCnt   <= '0;
      for (int unsigned k = 0; k < N; k++) regs[k] <= '0;
    end else begin
      BusValid <= driven;
      SelErr   <= multihot;
      if (driven) begin
        Bus <= nxt;
        for (int unsigned k = 0; k < N; k++) begin
          if (Rin[k]) regs[k] <= nxt;
        end
      end
      if (multihot && ErrCnt != '1) ErrCnt <= ErrCnt + 8'd1;
    end
  end

  always_comb begin
    RdData = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (RdSel == SW'(k)) RdData = regs[k];
    end
  end

endmodule

// File: tb/tb_bus_regfile.sv
// Randomized and directed checks of bus_regfile against a behavioural model,
// plus small-width, wide and non-power-of-two register-count instances.
module tb_bus_regfile;

  logic Clock = 1'b0;
  logic Resetn = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // main instance W=16 N=8
  logic [15:0] a_din = '0, a_g = '0;
  logic        a_dinout = 1'b0, a_gout = 1'b0;
  logic [7:0]  a_rout = '0, a_rin = '0;
  logic [2:0]  a_rdsel = '0;
  logic [15:0] a_bus, a_rddata;
  logic        a_busvalid, a_selerr;
  logic [7:0]  a_errcnt;

  bus_regfile #(.W(16), .N(8)) u0 (
    .Clock(Clock), .Resetn(Resetn), .DIN(a_din), .DINout(a_dinout), .G(a_g), .Gout(a_gout),
    .Rout(a_rout), .Rin(a_rin), .RdSel(a_rdsel), .Bus(a_bus), .BusValid(a_busvalid),
    .SelErr(a_selerr), .ErrCnt(a_errcnt), .RdData(a_rddata));

  // W=8 N=4
  logic [7:0] b_din = '0, b_g = '0, b_bus, b_rddata;
  logic       b_dinout = 1'b0, b_gout = 1'b0, b_busvalid, b_selerr;
  logic [3:0] b_rout = '0, b_rin = '0;
  logic [1:0] b_rdsel = '0;
  logic [7:0] b_errcnt;

  bus_regfile #(.W(8), .N(4)) u1 (
    .Clock(Clock), .Resetn(Resetn), .DIN(b_din), .DINout(b_dinout), .G(b_g), .Gout(b_gout),
    .Rout(b_rout), .Rin(b_rin), .RdSel(b_rdsel), .Bus(b_bus), .BusValid(b_busvalid),
    .SelErr(b_selerr), .ErrCnt(b_errcnt), .RdData(b_rddata));

  // W=32 N=16
  logic [31:0] c_din = '0, c_g = '0, c_bus, c_rddata;
  logic        c_dinout = 1'b0, c_gout = 1'b0, c_busvalid, c_selerr;
  logic [15:0] c_rout = '0, c_rin = '0;
  logic [3:0]  c_rdsel = '0;
  logic [7:0]  c_errcnt;

  bus_regfile #(.W(32), .N(16)) u2 (
    .Clock(Clock), .Resetn(Resetn), .DIN(c_din), .DINout(c_dinout), .G(c_g), .Gout(c_gout),
    .Rout(c_rout), .Rin(c_rin), .RdSel(c_rdsel), .Bus(c_bus), .BusValid(c_busvalid),
    .SelErr(c_selerr), .ErrCnt(c_errcnt), .RdData(c_rddata));

  // W=8 N=5: RdSel can name registers that do not exist
  logic [7:0] e_din = '0, e_g = '0, e_bus, e_rddata;
  logic       e_dinout = 1'b0, e_gout = 1'b0, e_busvalid, e_selerr;
  logic [4:0] e_rout = '0, e_rin = '0;
  logic [2:0] e_rdsel = '0;
  logic [7:0] e_errcnt;

  bus_regfile #(.W(8), .N(5)) u3 (
    .Clock(Clock), .Resetn(Resetn), .DIN(e_din), .DINout(e_dinout), .G(e_g), .Gout(e_gout),
    .Rout(e_rout), .Rin(e_rin), .RdSel(e_rdsel), .Bus(e_bus), .BusValid(e_busvalid),
    .SelErr(e_selerr), .ErrCnt(e_errcnt), .RdData(e_rddata));

  // reference model of u0
  logic [15:0] mr [8];
  logic [15:0] mbus;
  logic        mvalid, mserr;
  int          mcnt;

  task automatic model_reset();
    for (int k = 0; k < 8; k++) mr[k] = '0;
    mbus = '0; mvalid = 1'b0; mserr = 1'b0; mcnt = 0;
  endtask

  // drive one cycle on u0, advance the model, return #1 after the edge
  task automatic drive0(input logic [15:0] din, input logic dinout, input logic [15:0] g,
                        input logic gout, input logic [7:0] rout, input logic [7:0] rin,
                        input logic [2:0] rdsel);
    int ones;
    logic drv;
    logic [15:0] nxt;
    a_din = din; a_dinout = dinout; a_g = g; a_gout = gout;
    a_rout = rout; a_rin = rin; a_rdsel = rdsel;
    ones = $countones(rout);
    drv = 1'b1;
    nxt = '0;
    if (dinout) nxt = din;
    else if (gout) nxt = g;
    else if (ones == 1) begin
      for (int k = 0; k < 8; k++) if (rout[k]) nxt = mr[k];
    end else drv = 1'b0;
    mserr = !dinout && !gout && ones > 1;
    if (mserr && mcnt < 255) mcnt++;
    if (drv) begin
      for (int k = 0; k < 8; k++) if (rin[k]) mr[k] = nxt;
      mbus = nxt;
    end
    mvalid = drv;
    @(posedge Clock); #1;
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    model_reset();
    #12;
    if (a_bus !== 16'h0) begin errors++; $display("FAIL reset_bus got %h want 0", a_bus); end
    checks++;
    if (a_busvalid !== 1'b0 || a_selerr !== 1'b0) begin
      errors++; $display("FAIL reset_flags got %b%b want 00", a_busvalid, a_selerr);
    end
    checks++;
    if (a_errcnt !== 8'h0) begin errors++; $display("FAIL reset_errcnt got %0d want 0", a_errcnt); end
    checks++;
    for (int k = 0; k < 8; k++) begin
      a_rdsel = 3'(k); #1;
      if (a_rddata !== 16'h0) begin errors++; $display("FAIL reset_rd%0d got %h want 0", k, a_rddata); end
      checks++;
    end
    #2 Resetn = 1'b1;
  endtask

  task automatic test_din_move();
    drive0(16'hA5A5, 1'b1, 16'h0, 1'b0, 8'h00, 8'b0000_0100, 3'd2);
    if (a_bus !== 16'hA5A5 || a_busvalid !== 1'b1) begin
      errors++; $display("FAIL din_bus got %h/%b want a5a5/1", a_bus, a_busvalid);
    end
    checks++;
    if (a_rddata !== 16'hA5A5) begin errors++; $display("FAIL din_r2 got %h want a5a5", a_rddata); end
    checks++;
    drive0(16'h1111, 1'b0, 16'h0, 1'b0, 8'b0000_0100, 8'b1000_0000, 3'd7);
    if (a_rddata !== 16'hA5A5) begin errors++; $display("FAIL move_r7 got %h want a5a5", a_rddata); end
    checks++;
  endtask

  task automatic test_priority();
    drive0(16'h0001, 1'b1, 16'h0002, 1'b1, 8'b0000_0011, 8'h00, 3'd0);
    if (a_bus !== 16'h0001 || a_selerr !== 1'b0) begin
      errors++; $display("FAIL prio_din got %h/%b want 0001/0", a_bus, a_selerr);
    end
    checks++;
    drive0(16'h0001, 1'b0, 16'h0002, 1'b1, 8'b0000_0011, 8'h00, 3'd0);
    if (a_bus !== 16'h0002 || a_selerr !== 1'b0) begin
      errors++; $display("FAIL prio_g got %h/%b want 0002/0", a_bus, a_selerr);
    end
    checks++;
  endtask

  task automatic test_hold();
    drive0(16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 8'h00, 8'hFF, 3'd2);
    if (a_bus !== 16'h0002 || a_busvalid !== 1'b0) begin
      errors++; $display("FAIL hold_bus got %h/%b want 0002/0", a_bus, a_busvalid);
    end
    checks++;
    if (a_rddata !== 16'hA5A5) begin errors++; $display("FAIL hold_r2 got %h want a5a5", a_rddata); end
    checks++;
    a_rdsel = 3'd0; #1;
    if (a_rddata !== 16'h0) begin errors++; $display("FAIL hold_r0 got %h want 0", a_rddata); end
    checks++;
  endtask

  task automatic test_selerr();
    drive0(16'h0, 1'b0, 16'h0, 1'b0, 8'b0001_0001, 8'hFF, 3'd4);
    if (a_selerr !== 1'b1 || a_errcnt !== 8'd1) begin
      errors++; $display("FAIL err_pulse got %b/%0d want 1/1", a_selerr, a_errcnt);
    end
    checks++;
    if (a_bus !== 16'h0002 || a_busvalid !== 1'b0 || a_rddata !== 16'h0) begin
      errors++; $display("FAIL err_hold got %h/%b/%h want 0002/0/0000", a_bus, a_busvalid, a_rddata);
    end
    checks++;
    drive0(16'h0, 1'b0, 16'h0, 1'b0, 8'h00, 8'h00, 3'd4);
    if (a_selerr !== 1'b0 || a_errcnt !== 8'd1) begin
      errors++; $display("FAIL err_clear got %b/%0d want 0/1", a_selerr, a_errcnt);
    end
    checks++;
  endtask

  task automatic test_random();
    logic [7:0] rout;
    int i, j;
    for (int n = 0; n < 500; n++) begin
      case ($urandom_range(0, 3))
        0: rout = 8'h00;
        1, 2: rout = 8'(1) << $urandom_range(0, 7);
        default: begin
          i = $urandom_range(0, 7);
          j = (i + 1 + $urandom_range(0, 6)) % 8;
          rout = (8'(1) << i) | (8'(1) << j) | 8'($urandom);
        end
      endcase
      drive0(16'($urandom), $urandom_range(0, 3) == 0, 16'($urandom), $urandom_range(0, 3) == 0,
             rout, 8'($urandom), 3'($urandom));
      if (a_bus !== mbus || a_busvalid !== mvalid) begin
        errors++; $display("FAIL rnd_bus[%0d] got %h/%b want %h/%b", n, a_bus, a_busvalid, mbus, mvalid);
      end
      checks++;
      if (a_selerr !== mserr || a_errcnt !== 8'(mcnt)) begin
        errors++; $display("FAIL rnd_err[%0d] got %b/%0d want %b/%0d", n, a_selerr, a_errcnt, mserr, mcnt);
      end
      checks++;
      if (a_rddata !== mr[a_rdsel]) begin
        errors++; $display("FAIL rnd_rd[%0d] r%0d got %h want %h", n, a_rdsel, a_rddata, mr[a_rdsel]);
      end
      checks++;
    end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 300; n++) begin
      drive0(16'h0, 1'b0, 16'h0, 1'b0, 8'b0001_0001, 8'h00, 3'd0);
      if (a_errcnt !== 8'(mcnt) || a_selerr !== 1'b1) begin
        errors++; $display("FAIL sat_step[%0d] got %0d/%b want %0d/1", n, a_errcnt, a_selerr, mcnt);
      end
      checks++;
    end
    if (a_errcnt !== 8'd255) begin errors++; $display("FAIL sat_final got %0d want 255", a_errcnt); end
    checks++;
  endtask

  task automatic test_params();
    b_din = 8'hA5; b_dinout = 1'b1; b_rin = 4'b0100;
    c_din = 32'hA5A5_A5A5; c_dinout = 1'b1; c_rin = 16'h0004;
    e_din = 8'h3C; e_dinout = 1'b1; e_rin = 5'h1F;
    @(posedge Clock); #1;
    b_dinout = 1'b0; b_rout = 4'b0100; b_rin = 4'b1000; b_rdsel = 2'd3;
    c_dinout = 1'b0; c_rout = 16'h0004; c_rin = 16'h8000; c_rdsel = 4'd15;
    e_dinout = 1'b0; e_rin = '0; e_rdsel = 3'd4;
    if (b_bus !== 8'hA5 || c_bus !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL param_bus got %h/%h want a5/a5a5a5a5", b_bus, c_bus);
    end
    checks++;
    @(posedge Clock); #1;
    if (b_rddata !== 8'hA5) begin errors++; $display("FAIL w8_r3 got %h want a5", b_rddata); end
    checks++;
    if (c_rddata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL w32_r15 got %h want a5a5a5a5", c_rddata); end
    checks++;
    if (e_rddata !== 8'h3C) begin errors++; $display("FAIL n5_r4 got %h want 3c", e_rddata); end
    checks++;
    for (int k = 5; k < 8; k++) begin
      e_rdsel = 3'(k); #1;
      if (e_rddata !== 8'h00) begin errors++; $display("FAIL n5_oob%0d got %h want 0", k, e_rddata); end
      checks++;
    end
    b_rout = '0; b_rin = '0; c_rout = '0; c_rin = '0;
  endtask

  task automatic test_reset_mid_write();
    a_din = 16'hBEEF; a_dinout = 1'b1; a_gout = 1'b0; a_rout = '0; a_rin = 8'b0010_0000; a_rdsel = 3'd5;
    #3 Resetn = 1'b0;
    model_reset();
    #1;
    if (a_bus !== 16'h0 || a_busvalid !== 1'b0 || a_errcnt !== 8'h0) begin
      errors++; $display("FAIL async_rst got %h/%b/%0d want 0/0/0", a_bus, a_busvalid, a_errcnt);
    end
    checks++;
    @(posedge Clock); #3;
    a_dinout = 1'b0; a_rin = '0;
    Resetn = 1'b1;
    drive0(16'h0, 1'b0, 16'h0, 1'b0, 8'h00, 8'h00, 3'd5);
    if (a_rddata !== 16'h0 || a_bus !== 16'h0) begin
      errors++; $display("FAIL rst_write_r5 got %h/%h want 0/0", a_rddata, a_bus);
    end
    checks++;
    drive0(16'h1234, 1'b1, 16'h0, 1'b0, 8'h00, 8'b0010_0000, 3'd5);
    if (a_rddata !== 16'h1234 || a_errcnt !== 8'h0) begin
      errors++; $display("FAIL post_rst got %h/%0d want 1234/0", a_rddata, a_errcnt);
    end
    checks++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_din_move();
    test_priority();
    test_hold();
    test_selerr();
    test_random();
    test_saturation();
    test_params();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
